chdr_traffic_sink: RTL and testbench

- Synthesizable per-port traffic checker placed directly downstream of each crossbar/router output port; it consumes one AXI-Stream port.
- Checks routing, packet length and payload integrity of the test packets generated by the companion traffic sources.
- Measures per-packet latency against a shared cycle-count timestamp.
- Exposes counters for hardware self-test of the 2D mesh/torus crossbar.

---
 rtl/chdr_traffic_sink.sv | 230 +++++++++++++++++++++++
 tb/tb_chdr_traffic_sink.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/chdr_traffic_sink.sv
// chdr_traffic_sink: per-port checker for crossbar self-test packets (routing, length, payload, latency).
// Optional random backpressure when CHDR_TRAFFIC_SINK_BACKPRESSURE_EN is defined.
module chdr_traffic_sink #(
  parameter int WIDTH     = 64,
  parameter int NODE_ID   = 0,
  parameter int NUM_NODES = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       current_time,
  input  logic              start_stb,
  input  logic [31:0]       expected_pkts,
  input  logic [WIDTH-1:0]  s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              session_active,
  output logic [31:0]       xfer_count,
  output logic [31:0]       pkt_count,
  output logic [31:0]       route_err_count,
  output logic [31:0]       data_err_count,
  output logic [31:0]       len_err_count,
  output logic [63:0]       latency_sum,
  output logic [31:0]       latency_max
);

  localparam logic [15:0] NODE_ADDR = 16'(NODE_ID);
  localparam logic [15:0] NODE_CNT  = 16'(NUM_NODES);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_TS    = 2'd1,
    ST_BODY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endfunction

  function automatic logic [31:0] clamp32(input logic [63:0] v);
    return (v[63:32] != 32'd0) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  state_t       state_r, state_nxt_s;
  logic [15:0]  src_r, seq_r, len_r, idx_r, idx_nxt_s;
  logic [31:0]  expected_r;
  logic         route_flag_r, data_flag_r, len_flag_r, lat_valid_r;
  logic [63:0]  lat_r;
  logic         beat_s, eop_s, hdr_load_s, lat_load_s;
  logic         route_hit_s, data_hit_s, len_hit_s;
  logic         route_f_s, data_f_s, len_f_s, lat_valid_s;
  logic [63:0]  lat_s, expected_word_s;
  logic [31:0]  pkt_next_s;

  assign beat_s          = s_axis_tvalid & s_axis_tready;
  assign expected_word_s = {src_r, seq_r, 16'd0, idx_r};
  assign pkt_next_s      = pkt_count + 32'd1;

  // Per-packet error flags accumulate across beats; the final value includes this beat's findings.
  assign route_f_s   = route_flag_r | route_hit_s;
  assign data_f_s    = data_flag_r | data_hit_s;
  assign len_f_s     = len_flag_r | len_hit_s;
  assign lat_valid_s = lat_valid_r | lat_load_s;
  assign lat_s       = lat_load_s ? (current_time - s_axis_tdata) : lat_r;

  // Next-state and per-beat check decode.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    hdr_load_s  = 1'b0;
    lat_load_s  = 1'b0;
    route_hit_s = 1'b0;
    data_hit_s  = 1'b0;
    len_hit_s   = 1'b0;
    eop_s       = 1'b0;
    if (beat_s) begin
      eop_s = s_axis_tlast;
      case (state_r)
        ST_HDR: begin
          hdr_load_s  = 1'b1;
          idx_nxt_s   = 16'd1;
          route_hit_s = (s_axis_tdata[63:48] != NODE_ADDR) || (s_axis_tdata[47:32] >= NODE_CNT);
          if (s_axis_tlast || (s_axis_tdata[15:0] < 16'd2)) begin
            len_hit_s   = 1'b1;
            state_nxt_s = ST_HDR;
          end else begin
            state_nxt_s = ST_TS;
          end
        end
        ST_TS: begin
          lat_load_s = 1'b1;
          idx_nxt_s  = 16'd2;
          if (s_axis_tlast) begin
            len_hit_s   = (len_r != 16'd2);
            state_nxt_s = ST_HDR;
          end else if (len_r == 16'd2) begin
            len_hit_s   = 1'b1;
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_BODY;
          end
        end
        ST_BODY: begin
          data_hit_s = (s_axis_tdata != expected_word_s);
          if (s_axis_tlast) begin
            len_hit_s   = (idx_r != (len_r - 16'd1));
            state_nxt_s = ST_HDR;
          end else if (idx_r == (len_r - 16'd1)) begin
            len_hit_s   = 1'b1;
            state_nxt_s = ST_DRAIN;
          end else begin
            idx_nxt_s = idx_r + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (s_axis_tlast) begin
            state_nxt_s = ST_HDR;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          state_nxt_s = ST_HDR;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, header fields, per-packet flags and all counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_HDR;
      src_r           <= 16'd0;
      seq_r           <= 16'd0;
      len_r           <= 16'd0;
      idx_r           <= 16'd0;
      expected_r      <= 32'd0;
      route_flag_r    <= 1'b0;
      data_flag_r     <= 1'b0;
      len_flag_r      <= 1'b0;
      lat_valid_r     <= 1'b0;
      lat_r           <= 64'd0;
      session_active  <= 1'b0;
      xfer_count      <= 32'd0;
      pkt_count       <= 32'd0;
      route_err_count <= 32'd0;
      data_err_count  <= 32'd0;
      len_err_count   <= 32'd0;
      latency_sum     <= 64'd0;
      latency_max     <= 32'd0;
    end else if (start_stb) begin
      state_r         <= ST_HDR;
      idx_r           <= 16'd0;
      expected_r      <= expected_pkts;
      route_flag_r    <= 1'b0;
      data_flag_r     <= 1'b0;
      len_flag_r      <= 1'b0;
      lat_valid_r     <= 1'b0;
      session_active  <= 1'b1;
      xfer_count      <= 32'd0;
      pkt_count       <= 32'd0;
      route_err_count <= 32'd0;
      data_err_count  <= 32'd0;
      len_err_count   <= 32'd0;
      latency_sum     <= 64'd0;
      latency_max     <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (hdr_load_s) begin
        src_r <= s_axis_tdata[47:32];
        seq_r <= s_axis_tdata[31:16];
        len_r <= s_axis_tdata[15:0];
      end
      if (beat_s) begin
        xfer_count <= xfer_count + 32'd1;
      end
      if (eop_s) begin
        pkt_count    <= pkt_next_s;
        route_flag_r <= 1'b0;
        data_flag_r  <= 1'b0;
        len_flag_r   <= 1'b0;
        lat_valid_r  <= 1'b0;
        if (route_f_s) route_err_count <= sat_inc32(route_err_count);
        if (data_f_s)  data_err_count  <= sat_inc32(data_err_count);
        if (len_f_s)   len_err_count   <= sat_inc32(len_err_count);
        if (lat_valid_s) begin
          latency_sum <= sat_add64(latency_sum, lat_s);
          if (clamp32(lat_s) > latency_max) latency_max <= clamp32(lat_s);
        end
        if ((expected_r != 32'd0) && (pkt_next_s == expected_r)) session_active <= 1'b0;
      end else begin
        route_flag_r <= route_f_s;
        data_flag_r  <= data_f_s;
        len_flag_r   <= len_f_s;
        if (lat_load_s) begin
          lat_r       <= lat_s;
          lat_valid_r <= 1'b1;
        end
      end
    end
  end

`ifdef CHDR_TRAFFIC_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr_r;

  // Free-running LFSR (x^16+x^14+x^13+x^11+1) that randomly withholds ready.
  always_ff @(posedge clk) begin
    if (rst || start_stb) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign s_axis_tready = session_active & (lfsr_r[1:0] != 2'b00);
`else
  assign s_axis_tready = session_active;
`endif

endmodule

// File: tb/tb_chdr_traffic_sink.sv
// Directed self-checking bench for chdr_traffic_sink (NODE_ID=4, NUM_NODES=25).
module tb_chdr_traffic_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] current_time = 64'd0;
  logic        start_stb;
  logic [31:0] expected_pkts;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        session_active;
  logic [31:0] xfer_count, pkt_count, route_err_count, data_err_count, len_err_count, latency_max;
  logic [63:0] latency_sum;

  int   n_cmp = 0;
  int   n_err = 0;
  logic saw_low = 1'b0;

  chdr_traffic_sink #(.WIDTH(64), .NODE_ID(4), .NUM_NODES(25)) dut (
    .clk(clk), .rst(rst), .current_time(current_time),
    .start_stb(start_stb), .expected_pkts(expected_pkts),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .session_active(session_active), .xfer_count(xfer_count), .pkt_count(pkt_count),
    .route_err_count(route_err_count), .data_err_count(data_err_count),
    .len_err_count(len_err_count), .latency_sum(latency_sum), .latency_max(latency_max)
  );

  always #5 clk = ~clk;

  always @(posedge clk) current_time <= current_time + 64'd1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the beat until it is accepted, re-stamping timestamp beats.
  task automatic send_beat(input logic [63:0] w, input logic last, input logic is_ts);
    logic acc;
    acc = 1'b0;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      s_axis_tdata = is_ts ? (current_time - 64'd7) : w;
      acc = s_axis_tready;
      if (!acc) saw_low = 1'b1;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!acc) check_val("beat_accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_pkt(input logic [15:0] dst, input logic [15:0] src, input logic [15:0] seq,
                          input logic [15:0] len, input int first, input int last_line,
                          input logic [63:0] corrupt);
    logic [63:0] w;
    for (int k = first; k <= last_line; k++) begin
      if (k == 0)      w = {dst, src, seq, len};
      else if (k == 1) w = 64'd0;
      else             w = {src, seq, 32'(k)} ^ (corrupt[k] ? 64'h0000_0000_0000_00FF : 64'd0);
      send_beat(w, k == last_line, k == 1);
    end
  endtask

  task automatic start_session(input logic [31:0] n);
    start_stb     = 1'b1;
    expected_pkts = n;
    @(negedge clk);
    start_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_stb = 1'b0; expected_pkts = 32'd0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_session", session_active, 64'd0);
    check_val("rst_tready", s_axis_tready, 64'd0);
    check_val("rst_xfer", xfer_count, 64'd0);
    check_val("rst_pkt", pkt_count, 64'd0);
    check_val("rst_route", route_err_count, 64'd0);
    check_val("rst_lat_sum", latency_sum, 64'd0);
    check_val("rst_lat_max", latency_max, 64'd0);

    // Three good packets, session limited to 3.
    start_session(32'd3);
    check_val("start_session", session_active, 64'd1);
    for (int i = 0; i < 3; i++) begin
      send_pkt(16'd4, 16'd1, 16'(i), 16'd10, 0, 9, 64'd0);
      if (i == 1) check_val("session_mid", session_active, 64'd1);
    end
    check_val("good_pkt", pkt_count, 64'd3);
    check_val("good_xfer", xfer_count, 64'd30);
    check_val("good_route", route_err_count, 64'd0);
    check_val("good_data", data_err_count, 64'd0);
    check_val("good_len", len_err_count, 64'd0);
    check_val("good_lat_max", latency_max, 64'd7);
    check_val("good_lat_sum", latency_sum, 64'd21);
    check_val("end_session", session_active, 64'd0);
    check_val("end_tready", s_axis_tready, 64'd0);

    // Wrong destination.
    start_session(32'd0);
    send_pkt(16'd5, 16'd1, 16'd0, 16'd10, 0, 9, 64'd0);
    check_val("route_route", route_err_count, 64'd1);
    check_val("route_data", data_err_count, 64'd0);
    check_val("route_pkt", pkt_count, 64'd1);

    // Early tlast, then a good packet.
    start_session(32'd0);
    send_pkt(16'd4, 16'd2, 16'd0, 16'd10, 0, 5, 64'd0);
    send_pkt(16'd4, 16'd2, 16'd1, 16'd10, 0, 9, 64'd0);
    check_val("early_len", len_err_count, 64'd1);
    check_val("early_data", data_err_count, 64'd0);
    check_val("early_route", route_err_count, 64'd0);
    check_val("early_pkt", pkt_count, 64'd2);
    check_val("early_xfer", xfer_count, 64'd16);

    // Late tlast (len=4, 8 lines) drains, then a good packet.
    start_session(32'd0);
    send_pkt(16'd4, 16'd3, 16'd0, 16'd4, 0, 7, 64'd0);
    check_val("late_len", len_err_count, 64'd1);
    check_val("late_xfer", xfer_count, 64'd8);
    check_val("late_data", data_err_count, 64'd0);
    send_pkt(16'd4, 16'd3, 16'd1, 16'd10, 0, 9, 64'd0);
    check_val("late_next_len", len_err_count, 64'd1);
    check_val("late_next_data", data_err_count, 64'd0);
    check_val("late_next_pkt", pkt_count, 64'd2);

    // Two corrupted payload words count once.
    start_session(32'd0);
    send_pkt(16'd4, 16'd24, 16'd7, 16'd10, 0, 9, 64'h90);
    check_val("corrupt_data", data_err_count, 64'd1);
    check_val("corrupt_len", len_err_count, 64'd0);
    check_val("corrupt_route", route_err_count, 64'd0);

    // Restart mid-packet; the tail parses as header dst=1 src=9 len=3.
    start_session(32'd0);
    send_pkt(16'd4, 16'd1, 16'd9, 16'd10, 0, 2, 64'd0);
    start_session(32'd0);
    check_val("restart_xfer", xfer_count, 64'd0);
    check_val("restart_pkt", pkt_count, 64'd0);
    send_pkt(16'd4, 16'd1, 16'd9, 16'd10, 3, 9, 64'd0);
    check_val("abandon_pkt", pkt_count, 64'd1);
    check_val("abandon_xfer", xfer_count, 64'd7);
    check_val("abandon_route", route_err_count, 64'd1);
    check_val("abandon_len", len_err_count, 64'd1);
    check_val("abandon_data", data_err_count, 64'd1);
    check_val("abandon_lat_clamp", latency_max, 64'hFFFF_FFFF);

`ifdef CHDR_TRAFFIC_SINK_BACKPRESSURE_EN
    start_session(32'd50);
    for (int i = 0; i < 50; i++) send_pkt(16'd4, 16'd6, 16'(i), 16'd10, 0, 9, 64'd0);
    check_val("bp_pkt", pkt_count, 64'd50);
    check_val("bp_xfer", xfer_count, 64'd500);
    check_val("bp_errs", {route_err_count, data_err_count} | {32'd0, len_err_count}, 64'd0);
    check_val("bp_lat_max", latency_max, 64'd7);
    check_val("bp_session", session_active, 64'd0);
    check_val("bp_saw_ready_low", {63'd0, saw_low}, 64'd1);
`else
    check_val("no_bp_ready_low", {63'd0, saw_low}, 64'd0);
`endif

    // Synchronous reset mid-packet.
    start_session(32'd0);
    send_pkt(16'd4, 16'd1, 16'd0, 16'd10, 0, 2, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_xfer", xfer_count, 64'd0);
    check_val("midrst_session", session_active, 64'd0);
    check_val("midrst_tready", s_axis_tready, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
